// File: rtl/multdiv_ctrl_if.sv
// Bus between the X-stage mult/div sequencer (master) and the shared multdiv unit (slave).
interface multdiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             md_ctrl_mult;
  logic             md_ctrl_div;
  logic [WIDTH-1:0] md_operand_a;
  logic [WIDTH-1:0] md_operand_b;
  logic [WIDTH-1:0] md_result;
  logic             md_exception;
  logic             md_ready;

  modport master (
    output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
    input  md_result, md_exception, md_ready
  );

  modport slave (
    input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
    output md_result, md_exception, md_ready
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle mult/div unit: issue, start pulse, timeout, writeback beat.
// Optional MULTDIV_PERF_CNT_EN adds perf_ops / perf_stall_cycles counters.
module multdiv_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_mult,
  input  logic                issue_div,
  input  logic                issue_kill,
  input  logic [WIDTH-1:0]    op_a,
  input  logic [WIDTH-1:0]    op_b,
  input  logic [4:0]          op_rd,
  multdiv_ctrl_if.master      md,
  output logic                stall,
  output logic                busy,
  output logic                wb_valid,
  output logic [4:0]          wb_reg,
  output logic [WIDTH-1:0]    wb_data
`ifdef MULTDIV_PERF_CNT_EN
  ,
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]       RSTATUS  = 5'd30;

  state_t             state_r;
  logic               op_div_r;
  logic [WIDTH-1:0]   op_a_r;
  logic [WIDTH-1:0]   op_b_r;
  logic [4:0]         rd_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ctrl_mult_r;
  logic               ctrl_div_r;
  logic               busy_r;
  logic               run_stall_r;
  logic               wb_valid_r;
  logic [4:0]         wb_reg_r;
  logic [WIDTH-1:0]   wb_data_r;

  logic               issue_s;
  logic               stall_s;
  logic               timeout_s;

  // Exception code written to rstatus: 4 for mult, 5 for div.
  function automatic logic [WIDTH-1:0] exc_code(input logic is_div);
    exc_code = is_div ? WIDTH'(32'd5) : WIDTH'(32'd4);
  endfunction

  // Issue qualification and stall; the issue-cycle stall must be combinational.
  always_comb begin
    issue_s = 1'b0;
    if (state_r == IDLE) begin
      issue_s = (issue_mult | issue_div) & ~issue_kill;
    end else begin
      issue_s = 1'b0;
    end
    stall_s   = run_stall_r | issue_s;
    timeout_s = (cnt_r == CNT_LAST);
  end

  // Sequencer FSM with registered pulse, busy and writeback outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      op_div_r    <= 1'b0;
      op_a_r      <= {WIDTH{1'b0}};
      op_b_r      <= {WIDTH{1'b0}};
      rd_r        <= 5'd0;
      cnt_r       <= {CNT_W{1'b0}};
      ctrl_mult_r <= 1'b0;
      ctrl_div_r  <= 1'b0;
      busy_r      <= 1'b0;
      run_stall_r <= 1'b0;
      wb_valid_r  <= 1'b0;
      wb_reg_r    <= 5'd0;
      wb_data_r   <= {WIDTH{1'b0}};
    end else begin
      ctrl_mult_r <= 1'b0;
      ctrl_div_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            op_a_r      <= op_a;
            op_b_r      <= op_b;
            rd_r        <= op_rd;
            op_div_r    <= ~issue_mult;
            ctrl_mult_r <= issue_mult;
            ctrl_div_r  <= ~issue_mult;
            busy_r      <= 1'b1;
            run_stall_r <= 1'b1;
            state_r     <= START;
          end
        end
        START: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= BUSY;
        end
        BUSY: begin
          cnt_r <= cnt_r + CNT_ONE;
          // A ready result on the timeout cycle still wins over the forced exception.
          if (md.md_ready || timeout_s) begin
            state_r     <= DONE;
            run_stall_r <= 1'b0;
            if (md.md_ready && !md.md_exception) begin
              wb_valid_r <= (rd_r != 5'd0);
              wb_reg_r   <= rd_r;
              wb_data_r  <= (rd_r != 5'd0) ? md.md_result : {WIDTH{1'b0}};
            end else begin
              wb_valid_r <= 1'b1;
              wb_reg_r   <= RSTATUS;
              wb_data_r  <= exc_code(op_div_r);
            end
          end
        end
        DONE: begin
          wb_valid_r <= 1'b0;
          wb_reg_r   <= 5'd0;
          wb_data_r  <= {WIDTH{1'b0}};
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          wb_valid_r  <= 1'b0;
          wb_reg_r    <= 5'd0;
          wb_data_r   <= {WIDTH{1'b0}};
          busy_r      <= 1'b0;
          run_stall_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign md.md_ctrl_mult = ctrl_mult_r;
  assign md.md_ctrl_div  = ctrl_div_r;
  assign md.md_operand_a = op_a_r;
  assign md.md_operand_b = op_b_r;
  assign stall           = stall_s;
  assign busy            = busy_r;
  assign wb_valid        = wb_valid_r;
  assign wb_reg          = wb_reg_r;
  assign wb_data         = wb_data_r;

`ifdef MULTDIV_PERF_CNT_EN
  // Completed-operation and stall-cycle counters, free-running with wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_ops          <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      perf_ops          <= (state_r == DONE) ? perf_ops + 32'd1 : perf_ops;
      perf_stall_cycles <= stall_s ? perf_stall_cycles + 32'd1 : perf_stall_cycles;
    end
  end
`endif

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the shared multi-cycle multiplier/divider in the X stage of the 5-stage pipeline. It accepts a mult/div issue from the DX latch and latches the operands and destination. It pulses ctrl_MULT/ctrl_DIV to the multdiv unit, stalls PC/FD/DX while the operation runs, and enforces a timeout. It then presents one writeback beat, either the result to rd or the exception code to rstatus (r30).

Parameters:
WIDTH, 32, operand/result width
TIMEOUT_CYCLES, 40, maximum BUSY cycles before a forced exception
CNT_W, 6, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clock  in  1  master clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset)
issue_mult  in  1  DX holds a mult (opcode 00000, ALU op 00110)
issue_div  in  1  DX holds a div (opcode 00000, ALU op 00111)
issue_kill  in  1  DX instruction is being flushed; blocks issue
op_a  in  WIDTH  DX operand A
op_b  in  WIDTH  DX operand B
op_rd  in  5  DX destination register
md_ctrl_mult  out  1  one-cycle start pulse, multiply
md_ctrl_div  out  1  one-cycle start pulse, divide
md_operand_a  out  WIDTH  latched operand A
md_operand_b  out  WIDTH  latched operand B
md_result  in  WIDTH  multdiv data_result
md_exception  in  1  multdiv data_exception
md_ready  in  1  multdiv data_resultRDY
stall  out  1  freeze PC, FD and DX latches
busy  out  1  state != IDLE
wb_valid  out  1  writeback beat valid
wb_reg  out  5  writeback register
wb_data  out  WIDTH  writeback data

Behaviour:
- States: IDLE, START, BUSY, DONE. Encoding is free.
- Reset (reset=0, async): state=IDLE. Latched A/B/rd/op=0, counter=0. All outputs 0, and md_ctrl_* are held 0 immediately. Reset mid-operation abandons the op with no writeback.
- IDLE: issue = (issue_mult|issue_div) & ~issue_kill.
  - stall = issue, combinational in the same cycle.
  - On issue at the edge: latch op_a, op_b, op_rd, and op (mult wins if both issue_* are high). Go to START.
- START: assert md_ctrl_mult or md_ctrl_div for exactly this cycle. md_operand_* are stable from this cycle until IDLE. md_ready is ignored. Clear the counter. stall=1. Next state is BUSY.
- BUSY: stall=1; counter increments every cycle.
  - md_ready=1: capture md_result and md_exception. Go to DONE.
  - Else, counter==TIMEOUT_CYCLES-1: capture exception=1. Go to DONE.
  - md_ready on the timeout cycle takes priority (the result is used).
- DONE: stall=0, so DX advances at this edge. Drive a single-cycle writeback:
  - No exception: wb_reg=latched rd, wb_data=captured result, wb_valid = (rd != 0).
  - Exception: wb_reg=30, wb_data=4 for mult or 5 for div, wb_valid=1.
  - Next state is IDLE unconditionally. An issue cannot be accepted in DONE.
- wb_reg and wb_data are 0 whenever wb_valid=0.
- Latency: issue cycle, then START, then at least 1 BUSY cycle, then DONE. With md_ready in the first BUSY cycle, wb_valid rises 3 cycles after the issue cycle.
- busy=1 in START, BUSY and DONE.
- issue_* inputs are ignored outside IDLE.

Optional Feature:
MULTDIV_PERF_CNT_EN
- Defined: adds output ports perf_ops[31:0] and perf_stall_cycles[31:0].
  - perf_ops increments once per DONE.
  - perf_stall_cycles increments on every cycle with stall=1.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. mult, op_a=6, op_b=7, op_rd=5; bench raises md_ready with md_result=42 after 16 BUSY cycles -> one md_ctrl_mult pulse; stall high for 18 cycles; one wb_valid beat with wb_reg=5, wb_data=42.
2. div, op_a=9, op_b=0, rd=3; md_ready with md_exception=1 -> wb_reg=30, wb_data=5, wb_valid=1; rd 3 untouched.
3. mult, md_ready never asserted -> after 40 BUSY cycles wb_reg=30, wb_data=4; state returns to IDLE and stall drops in the DONE cycle.
4. mult with op_rd=0, result 99 -> no wb_valid beat; stall sequence identical to scenario 1. Separately, issue_mult with issue_kill=1 -> no pulse, stall=0, stays IDLE.
5. reset driven low in BUSY cycle 5 -> asynchronously stall=0, busy=0, no writeback. A new div issue after release runs normally, e.g. 20/4 -> wb_data=5.
6. With MULTDIV_PERF_CNT_EN: scenarios 1 and 2 back-to-back (md_ready after 1 cycle in scenario 2) -> perf_ops=2, perf_stall_cycles=18+3=21.
